// File: rtl/riscv_ctrl_pkg.sv
// Shared controller types: FSM state enum, opcodes, mux-select encodings, control word.
// MAIN_FSM_ILLEGAL_TRAP_EN adds the ILLEGAL state to the enum.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    , S_ILLEGAL
`endif
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_instr;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_if.sv
// Controller <-> datapath/memory signal bundle for main_fsm, plus the FSM state as a debug view.
interface main_fsm_if;
  import riscv_ctrl_pkg::*;

  // mem_ready is the memory's ready for the access currently presented: an access
  // completes only in a cycle where mem_ready=1, and the FSM holds its state otherwise.
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal_instr;
  state_t     state;

  modport master (
    input  op, zero, mem_ready,
    output pc_write, adr_src, ir_write, mem_write, reg_write,
    output result_src, alu_src_a, alu_src_b, alu_op, illegal_instr, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, adr_src, ir_write, mem_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, alu_op, illegal_instr, state
  );
endinterface

// File: rtl/main_fsm_outdec.sv
// Moore output decode: state -> control word; mem_ready gates fetch, zero gates branch.
// MAIN_FSM_ILLEGAL_TRAP_EN enables decoding of the ILLEGAL state.
module main_fsm_outdec
  import riscv_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  logic pc_update;
  logic branch;

  always_comb begin
    ctrl       = '0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.adr_src    = 1'b0;
        ctrl.ir_write   = mem_ready;
        pc_update       = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = 1'b1;
        ctrl.mem_write  = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_RD2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RD1;
        ctrl.alu_src_b  = SRCB_RD2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        branch          = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        pc_update       = 1'b1;
      end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      S_ILLEGAL: ctrl.illegal_instr = 1'b1;
`endif
      default: ctrl = '0;
    endcase
    // Branch resolves combinationally from zero in the BEQ cycle.
    ctrl.pc_write = pc_update | (branch & zero);
  end

endmodule

// File: rtl/main_fsm.sv
// Multi-cycle RISC-V main control FSM: state register, next-state logic, reset gating of outputs.
// MAIN_FSM_ILLEGAL_TRAP_EN: unknown opcodes trap in ILLEGAL instead of being skipped.
module main_fsm
  import riscv_ctrl_pkg::*;
(
  input logic       clk,
  input logic       reset,
  main_fsm_if.master bus
);

  state_t state;
  state_t state_next;
  state_t dec_state;
  ctrl_t  raw;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
          default:      state_next = S_ILLEGAL;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_next = S_MEMWB;
      S_MEMWRITE: if (bus.mem_ready) state_next = S_FETCH;
      S_MEMWB:    state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      S_ILLEGAL:  state_next = S_ILLEGAL;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  // During reset the selects show FETCH values even if the register still holds a mid-instruction state.
  assign dec_state = reset ? S_FETCH : state;

  main_fsm_outdec u_outdec (
    .state     (dec_state),
    .mem_ready (bus.mem_ready),
    .zero      (bus.zero),
    .ctrl      (raw)
  );

  assign bus.pc_write      = raw.pc_write & ~reset;
  assign bus.ir_write      = raw.ir_write & ~reset;
  assign bus.mem_write     = raw.mem_write & ~reset;
  assign bus.reg_write     = raw.reg_write & ~reset;
  assign bus.adr_src       = raw.adr_src;
  assign bus.result_src    = raw.result_src;
  assign bus.alu_src_a     = raw.alu_src_a;
  assign bus.alu_src_b     = raw.alu_src_b;
  assign bus.alu_op        = raw.alu_op;
  assign bus.illegal_instr = raw.illegal_instr;
  assign bus.state         = state;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: per-instruction step plans from the opcode rules, random waits/zero/aborts.
// Build with or without MAIN_FSM_ILLEGAL_TRAP_EN.
module tb_main_fsm;
  import riscv_ctrl_pkg::*;

  localparam int CW = $bits(ctrl_t);
  localparam int W  = $bits(state_t) + CW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  main_fsm_if bus();

  main_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef enum {T_F, T_D, T_MA, T_MR, T_MW, T_MWB, T_ER, T_EI, T_AWB, T_BQ, T_JL, T_IL} step_e;
  typedef struct {
    step_e s;
    logic  mr;
  } slot_t;

  slot_t        plan[$];
  logic [W-1:0] exp_q[$];
  logic         chk_state_q[$];
  string        name_q[$];

  // Expected control word per step, straight from the output table.
  function automatic ctrl_t exp_ctrl(step_e s, logic mr, logic z);
    ctrl_t c = '0;
    case (s)
      T_F:   begin c.alu_src_b = 2'b10; c.result_src = 2'b10; c.ir_write = mr; c.pc_write = mr; end
      T_D:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      T_MA:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      T_MR:  begin c.adr_src = 1'b1; end
      T_MW:  begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      T_MWB: begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      T_ER:  begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      T_EI:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      T_AWB: begin c.reg_write = 1'b1; end
      T_BQ:  begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.pc_write = z; end
      T_JL:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
      T_IL:  begin c.illegal_instr = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t exp_state(step_e s);
    case (s)
      T_D:   return S_DECODE;
      T_MA:  return S_MEMADR;
      T_MR:  return S_MEMREAD;
      T_MW:  return S_MEMWRITE;
      T_MWB: return S_MEMWB;
      T_ER:  return S_EXECR;
      T_EI:  return S_EXECI;
      T_AWB: return S_ALUWB;
      T_BQ:  return S_BEQ;
      T_JL:  return S_JAL;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      T_IL:  return S_ILLEGAL;
`endif
      default: return S_FETCH;
    endcase
  endfunction

  // One cycle of stimulus; the expectation for that cycle goes on the queue.
  task automatic drive(input logic rst, input logic [6:0] op_v, input logic z, input logic mr,
                       input logic [W-1:0] e, input logic chk_st, input string nm);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.op        = op_v;
    bus.zero      = z;
    bus.mem_ready = mr;
    exp_q.push_back(e);
    chk_state_q.push_back(chk_st);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input int n, input int mr_sel);
    logic mr;
    for (int i = 0; i < n; i++) begin
      mr = (mr_sel < 0) ? 1'($urandom) : mr_sel[0];
      drive(1'b1, 7'($urandom), 1'($urandom), mr, {S_FETCH, exp_ctrl(T_F, 1'b0, 1'b0)}, 1'b0, "reset");
    end
  endtask

  task automatic add(input step_e s, input logic mr);
    slot_t t;
    t.s  = s;
    t.mr = mr;
    plan.push_back(t);
  endtask

  // Builds the step plan for one instruction, then plays it; abort_at>=0 resets before that step.
  task automatic run_instr(input logic [6:0] op, input int fetch_wait, input int mem_wait,
                           input int zsel, input int abort_at);
    logic   z;
    step_e  s;
    plan.delete();
    repeat (fetch_wait) add(T_F, 1'b0);
    add(T_F, 1'b1);
    add(T_D, 1'($urandom));
    case (op)
      OP_LW: begin
        add(T_MA, 1'($urandom));
        repeat (mem_wait) add(T_MR, 1'b0);
        add(T_MR, 1'b1);
        add(T_MWB, 1'($urandom));
      end
      OP_SW: begin
        add(T_MA, 1'($urandom));
        repeat (mem_wait) add(T_MW, 1'b0);
        add(T_MW, 1'b1);
      end
      OP_RTYPE: begin add(T_ER, 1'($urandom)); add(T_AWB, 1'($urandom)); end
      OP_ITYPE: begin add(T_EI, 1'($urandom)); add(T_AWB, 1'($urandom)); end
      OP_BEQ:   add(T_BQ, 1'($urandom));
      OP_JAL:   begin add(T_JL, 1'($urandom)); add(T_AWB, 1'($urandom)); end
      default: begin
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        repeat (3) add(T_IL, 1'($urandom));
`endif
      end
    endcase
    foreach (plan[i]) begin
      if (i == abort_at) begin
        do_reset(2, -1);
        return;
      end
      s = plan[i].s;
      z = (zsel < 0) ? 1'($urandom) : zsel[0];
      drive(1'b0, (s == T_F) ? 7'($urandom) : op, z, plan[i].mr,
            {exp_state(s), exp_ctrl(s, plan[i].mr, z)}, 1'b1,
            $sformatf("op%b.%s", op, s.name()));
    end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    if (plan[plan.size()-1].s == T_IL) do_reset(1, -1);
`endif
  endtask

  // Monitor: one DUT output sample per cycle, compared against the queue head.
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    logic         chk_st;
    string        nm;
    ctrl_t        a;
    if (exp_q.size() > 0) begin
      exp_v  = exp_q.pop_front();
      chk_st = chk_state_q.pop_front();
      nm     = name_q.pop_front();
      a.pc_write      = bus.pc_write;
      a.adr_src       = bus.adr_src;
      a.ir_write      = bus.ir_write;
      a.mem_write     = bus.mem_write;
      a.reg_write     = bus.reg_write;
      a.result_src    = bus.result_src;
      a.alu_src_a     = bus.alu_src_a;
      a.alu_src_b     = bus.alu_src_b;
      a.alu_op        = bus.alu_op;
      a.illegal_instr = bus.illegal_instr;
      act_v  = {bus.state, a};
      checks = checks + 1;
      if (chk_st ? (act_v !== exp_v) : (act_v[CW-1:0] !== exp_v[CW-1:0])) begin
        errors = errors + 1;
        $display("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 nm, act_v[W-1:CW], act_v[CW-1:0], exp_v[W-1:CW], exp_v[CW-1:0]);
      end
    end
  end

  initial begin
    logic [6:0] ops[8];
    logic [6:0] op_r;
    int         ab;
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL, 7'b1111111, 7'b0000000};
    bus.op        = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    do_reset(3, 1);
    run_instr(OP_RTYPE, 0, 0, -1, -1);
    run_instr(OP_LW,    0, 2, -1, -1);
    run_instr(OP_SW,    0, 1, -1, -1);
    run_instr(OP_BEQ,   0, 0,  1, -1);
    run_instr(OP_BEQ,   0, 0,  0, -1);
    run_instr(OP_JAL,   1, 0, -1, -1);
    run_instr(OP_ITYPE, 2, 0, -1, -1);
    run_instr(7'b1111111, 0, 0, -1, -1);
    run_instr(OP_SW,    0, 2, -1, 3);

    for (int n = 0; n < 300; n++) begin
      op_r = ops[$urandom_range(0, 7)];
      ab   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : -1;
      run_instr(op_r, $urandom_range(0, 2), $urandom_range(0, 2), -1, ab);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multi-cycle main control state machine for the RISC-V core. Sequences one instruction at a time through fetch, decode, address/execute, memory and writeback, driving the datapath's write enables and mux selects from the opcode in the instruction register. Produces `alu_op` for the sibling ALU decoder and sits beside it inside the controller.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 7: opcode from the instruction register; valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: unified memory completes the current access this cycle.
- `pc_write` out 1: `pc_update | (branch & zero)`.
- `adr_src` out 1: 0 = PC, 1 = Result.
- `ir_write` out 1: load the instruction register (and OldPC).
- `mem_write` out 1: store strobe.
- `reg_write` out 1: register-file write.
- `result_src` out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a` out 2: 00 = PC, 01 = OldPC, 10 = RD1.
- `alu_src_b` out 2: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = use funct fields.
- `illegal_instr` out 1: sticky illegal-opcode flag.

## Operation
- Moore FSM. Outputs decode from the state only, except the `mem_ready` gating and the `zero` term in `pc_write`. Unlisted outputs are 0.
- **FETCH**: a_src=00, b_src=10, alu_op=00, result_src=10, adr_src=0.
  - `ir_write` = `pc_update` = `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE**: a_src=01, b_src=01, alu_op=00. Next state by `op`:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other value -> see Configuration
- **MEMADR**: a_src=10, b_src=01, alu_op=00. Goes to MEMREAD if `op`=0000011, otherwise MEMWRITE.
- **MEMREAD**: result_src=00, adr_src=1. Goes to MEMWB when `mem_ready`.
- **MEMWRITE**: result_src=00, adr_src=1, `mem_write`=1. `mem_write` stays asserted while waiting; goes to FETCH when `mem_ready`.
- **MEMWB**: result_src=01, `reg_write`. Goes to FETCH.
- **EXECR**: a_src=10, b_src=00, alu_op=10. Goes to ALUWB.
- **EXECI**: a_src=10, b_src=01, alu_op=10. Goes to ALUWB.
- **ALUWB**: result_src=00, `reg_write`. Goes to FETCH.
- **BEQ**: a_src=10, b_src=00, alu_op=01, result_src=00, `branch`=1. Goes to FETCH.
- **JAL**: a_src=01, b_src=10, alu_op=00, result_src=00, `pc_update`=1. Goes to ALUWB.

## Timing
- While `reset`=1, `pc_write`, `ir_write`, `reg_write` and `mem_write` are forced to 0. Selects show FETCH values, `illegal_instr`=0, and the state loads FETCH at the edge.
- Reset asserted mid-instruction aborts it. No write enable may assert in the reset cycle.
- Cycles per instruction with `mem_ready` held at 1: lw 5, sw 4, R/I 4, jal 4, beq 3.
- Each cycle of low `mem_ready` in FETCH, MEMREAD or MEMWRITE adds one cycle.
- A branch is taken only through `zero` sampled in the BEQ cycle. `pc_write` is combinational from `zero` in that cycle.
- `op` is sampled in DECODE and MEMADR only.

## Configuration
- `MAIN_FSM_ILLEGAL_TRAP_EN` defined:
  - An unknown `op` in DECODE goes to ILLEGAL.
  - ILLEGAL holds with all enables 0 and `illegal_instr`=1; only `reset` exits it.
- `MAIN_FSM_ILLEGAL_TRAP_EN` undefined:
  - An unknown `op` returns to FETCH. The instruction is skipped; the PC was already advanced in FETCH.
  - `illegal_instr` is tied to 0 and there is no ILLEGAL state.

## Structure
- Shared package `riscv_ctrl_pkg`:
  - state enum
  - opcode constants (LW, SW, RTYPE, ITYPE, BEQ, JAL)
  - encodings for `result_src`, `alu_src_a`, `alu_src_b` and `alu_op`
- One combinational sub-module, `main_fsm_outdec`, maps state, `mem_ready` and `zero` to the output vector.
- The state register and next-state logic stay in `main_fsm`.

## Test plan
- Reset held 3 cycles with `mem_ready`=1 -> all enables 0. After release, FETCH asserts `ir_write`=1, `pc_write`=1, b_src=10.
- R-type, op=0110011, `mem_ready`=1 -> states FETCH, DECODE, EXECR, ALUWB. `alu_op`=10 in EXECR; `reg_write`=1 only in cycle 4.
- lw, op=0000011, with `mem_ready` low 2 cycles in MEMREAD -> 7 cycles total. `result_src`=01 with `reg_write` in MEMWB.
- sw, op=0100011, with `mem_ready` low 1 cycle in MEMWRITE -> `mem_write`=1 for 2 consecutive cycles, then FETCH.
- beq, op=1100011, run once with `zero`=1 and once with `zero`=0 -> `pc_write` is 1 and then 0 in BEQ; `alu_op`=01.
- op=1111111 -> with the macro: ILLEGAL, `illegal_instr`=1 until reset. Without the macro: back to FETCH on the cycle after DECODE.
